// File: rtl/background_writer.sv
// Rectangle-fill write engine for the half-resolution background buffer.
// Accepts one clipped fill command at a time and emits one raster-ordered write per unstalled cycle.
module background_writer #(
  parameter int BUF_W = 320,
  parameter int BUF_H = 240
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [8:0]  cmd_x0,
  input  logic [7:0]  cmd_y0,
  input  logic [8:0]  cmd_w,
  input  logic [7:0]  cmd_h,
  input  logic [3:0]  cmd_color,
  input  logic        wr_stall,
  output logic        write_en,
  output logic [18:0] write_address,
  output logic [3:0]  write_data,
  output logic        busy,
  output logic        done
);

  // Handshake: a command transfers on the rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, and the command fields matter only on that edge.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [9:0]  BUF_W10 = 10'(BUF_W);
  localparam logic [9:0]  BUF_H10 = 10'(BUF_H);
  localparam logic [18:0] BUF_W19 = 19'(BUF_W);

  state_t      state_q, state_d;
  logic [8:0]  x_q, x_d;
  logic [8:0]  x0_q, x0_d;
  logic [9:0]  x_end_q, x_end_d;
  logic [7:0]  y_q, y_d;
  logic [9:0]  y_end_q, y_end_d;
  logic [18:0] row_base_q, row_base_d;
  logic [3:0]  color_q, color_d;

  logic [9:0]  x_sum;
  logic [9:0]  y_sum;
  logic        empty;
  logic        last_x;
  logic        last_y;

  assign x_sum  = {1'b0, cmd_x0} + {1'b0, cmd_w};
  assign y_sum  = {2'b0, cmd_y0} + {2'b0, cmd_h};
  assign empty  = (cmd_w == 9'd0) || (cmd_h == 8'd0) ||
                  ({1'b0, cmd_x0} >= BUF_W10) || ({2'b0, cmd_y0} >= BUF_H10);
  assign last_x = (({1'b0, x_q} + 10'd1) == x_end_q);
  assign last_y = (({2'b0, y_q} + 10'd1) == y_end_q);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    x0_d       = x0_q;
    x_end_d    = x_end_q;
    y_d        = y_q;
    y_end_d    = y_end_q;
    row_base_d = row_base_q;
    color_d    = color_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          x_d        = cmd_x0;
          x0_d       = cmd_x0;
          y_d        = cmd_y0;
          x_end_d    = (x_sum > BUF_W10) ? BUF_W10 : x_sum;
          y_end_d    = (y_sum > BUF_H10) ? BUF_H10 : y_sum;
          // The only multiply happens once per command; pixels use adds only.
          row_base_d = 19'(cmd_y0) * BUF_W19;
          color_d    = cmd_color;
          state_d    = empty ? DONE : FILL;
        end
      end
      FILL: begin
        if (!wr_stall) begin
          if (last_x) begin
            x_d = x0_q;
            if (last_y) begin
              state_d = DONE;
            end else begin
              y_d        = y_q + 8'd1;
              row_base_d = row_base_q + BUF_W19;
            end
          end else begin
            x_d = x_q + 9'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      x0_q       <= '0;
      x_end_q    <= '0;
      y_q        <= '0;
      y_end_q    <= '0;
      row_base_q <= '0;
      color_q    <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      x0_q       <= x0_d;
      x_end_q    <= x_end_d;
      y_q        <= y_d;
      y_end_q    <= y_end_d;
      row_base_q <= row_base_d;
      color_q    <= color_d;
    end
  end

  assign cmd_ready     = (state_q == IDLE);
  assign busy          = (state_q == FILL) || (state_q == DONE);
  assign done          = (state_q == DONE);
  // wr_stall gates the strobe directly; everything else comes from registers.
  assign write_en      = (state_q == FILL) && !wr_stall;
  assign write_address = row_base_q + 19'(x_q);
  assign write_data    = color_q;

endmodule

// File: tb/tb_background_writer.sv
// Directed bench for background_writer: a vector table of fill commands with hand-computed
// write counts, end addresses and done cycles, plus a reset-during-fill sequence.
module tb_background_writer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_x0;
  logic [7:0]  cmd_y0;
  logic [8:0]  cmd_w;
  logic [7:0]  cmd_h;
  logic [3:0]  cmd_color;
  logic        wr_stall;
  logic        write_en;
  logic [18:0] write_address;
  logic [3:0]  write_data;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [18:0] exp_q[$];

  typedef struct {
    logic [8:0]  x0;
    logic [7:0]  y0;
    logic [8:0]  w;
    logic [7:0]  h;
    logic [3:0]  color;
    logic [31:0] stall;
    bit          hold;
    int          exp_n;
    int          exp_first;
    int          exp_last;
    int          exp_done;
  } vec_t;

  vec_t vecs[10];

  background_writer #(.BUF_W(320), .BUF_H(240)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_x0        (cmd_x0),
    .cmd_y0        (cmd_y0),
    .cmd_w         (cmd_w),
    .cmd_h         (cmd_h),
    .cmd_color     (cmd_color),
    .wr_stall      (wr_stall),
    .write_en      (write_en),
    .write_address (write_address),
    .write_data    (write_data),
    .busy          (busy),
    .done          (done)
  );

  // Clock / reset
  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Drives one command starting just after a rising edge, follows it until cmd_ready returns.
  task automatic run_cmd(input int idx, input vec_t v);
    int xe, ye, cyc, n, stalls, done_cnt, done_cyc, ready_cyc, first_a, last_a, budget;
    bit finished, seq_bad, fill_now;
    logic [18:0] a;
    xe = int'(v.x0) + int'(v.w);
    if (xe > 320) xe = 320;
    ye = int'(v.y0) + int'(v.h);
    if (ye > 240) ye = 240;
    exp_q.delete();
    if (v.w != 0 && v.h != 0)
      for (int yy = int'(v.y0); yy < ye; yy++)
        for (int xx = int'(v.x0); xx < xe; xx++)
          exp_q.push_back(19'(xx + yy * 320));

    cmd_x0 = v.x0; cmd_y0 = v.y0; cmd_w = v.w; cmd_h = v.h; cmd_color = v.color;
    cmd_valid = 1'b1;
    wr_stall = 1'b0;
    @(negedge Clk);
    check($sformatf("v%0d ready_c0", idx), int'(cmd_ready), 1);
    @(posedge Clk); #1;
    // Different fields afterwards must not disturb the running command.
    cmd_valid = v.hold;
    cmd_x0 = 9'd1; cmd_y0 = 8'd1; cmd_w = 9'd1; cmd_h = 8'd1; cmd_color = ~v.color;

    cyc = 1; n = 0; stalls = 0; done_cnt = 0; done_cyc = -1; ready_cyc = -1;
    first_a = -1; last_a = -1; finished = 0; seq_bad = 0;
    budget = v.exp_done + 10;
    while (!finished) begin
      wr_stall = (cyc < 32) ? v.stall[cyc] : 1'b0;
      @(negedge Clk);
      fill_now = busy && !done;
      if (fill_now && wr_stall) begin
        check($sformatf("v%0d stall_wen", idx), int'(write_en), 0);
        if (exp_q.size() > 0)
          check($sformatf("v%0d stall_addr", idx), int'(write_address), int'(exp_q[0]));
        stalls++;
      end
      if (write_en) begin
        n++;
        if (exp_q.size() == 0) begin
          check($sformatf("v%0d extra_write", idx), n, v.exp_n);
        end else begin
          a = exp_q.pop_front();
          check($sformatf("v%0d addr", idx), int'(write_address), int'(a));
          check($sformatf("v%0d data", idx), int'(write_data), int'(v.color));
          check($sformatf("v%0d wcycle", idx), cyc, n + stalls);
        end
        if (n == 1) first_a = int'(write_address);
        last_a = int'(write_address);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy != (cyc <= v.exp_done)) seq_bad = 1;
      if (cmd_ready != (cyc > v.exp_done)) seq_bad = 1;
      if (cmd_ready) begin
        ready_cyc = cyc;
        cmd_valid = 1'b0;
        finished = 1;
      end else if (cyc >= budget) begin
        check($sformatf("v%0d timeout", idx), cyc, v.exp_done + 1);
        finished = 1;
      end
      cyc++;
      if (!finished) begin
        @(posedge Clk); #1;
      end
    end
    cmd_valid = 1'b0;
    wr_stall = 1'b0;
    @(posedge Clk); #1;

    check($sformatf("v%0d nwrites", idx), n, v.exp_n);
    check($sformatf("v%0d done_pulses", idx), done_cnt, 1);
    check($sformatf("v%0d done_cycle", idx), done_cyc, v.exp_done);
    check($sformatf("v%0d ready_cycle", idx), ready_cyc, v.exp_done + 1);
    check($sformatf("v%0d busy_ready_seq", idx), int'(seq_bad), 0);
    check($sformatf("v%0d missing_writes", idx), exp_q.size(), 0);
    if (v.exp_n > 0) begin
      check($sformatf("v%0d first_addr", idx), first_a, v.exp_first);
      check($sformatf("v%0d last_addr", idx), last_a, v.exp_last);
    end
  endtask

  initial begin
    int nw;
    //            x0      y0      w        h       color  stall        hold  n      first  last   done
    vecs[0] = '{9'd10,  8'd2,   9'd3,   8'd2,   4'h5, 32'd0,       1'b0, 6,     650,   972,   7};
    vecs[1] = '{9'd318, 8'd239, 9'd5,   8'd4,   4'hA, 32'd0,       1'b0, 2,     76798, 76799, 3};
    vecs[2] = '{9'd5,   8'd5,   9'd0,   8'd3,   4'h1, 32'd0,       1'b0, 0,     0,     0,     1};
    vecs[3] = '{9'd320, 8'd0,   9'd4,   8'd4,   4'h2, 32'd0,       1'b0, 0,     0,     0,     1};
    vecs[4] = '{9'd0,   8'd240, 9'd4,   8'd4,   4'h3, 32'd0,       1'b0, 0,     0,     0,     1};
    vecs[5] = '{9'd0,   8'd0,   9'd1,   8'd0,   4'h4, 32'd0,       1'b0, 0,     0,     0,     1};
    vecs[6] = '{9'd0,   8'd0,   9'd2,   8'd1,   4'h7, 32'b110,     1'b0, 2,     0,     1,     5};
    vecs[7] = '{9'd100, 8'd50,  9'd1,   8'd1,   4'hF, 32'd0,       1'b0, 1,     16100, 16100, 2};
    vecs[8] = '{9'd319, 8'd0,   9'd1,   8'd3,   4'h9, 32'd0,       1'b0, 3,     319,   959,   4};
    vecs[9] = '{9'd0,   8'd0,   9'd320, 8'd240, 4'hC, 32'd0,       1'b1, 76800, 0,     76799, 76801};

    Reset = 1'b0; cmd_valid = 1'b0; wr_stall = 1'b0;
    cmd_x0 = '0; cmd_y0 = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    repeat (2) @(posedge Clk);
    #1;
    @(negedge Clk);
    check("rst write_en", int'(write_en), 0);
    check("rst cmd_ready", int'(cmd_ready), 1);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst addr", int'(write_address), 0);
    check("rst data", int'(write_data), 0);
    @(posedge Clk); #1;
    Reset = 1'b1;

    for (int i = 0; i < 9; i++) run_cmd(i, vecs[i]);

    // Reset during the 4th write of a 4x4 fill.
    cmd_x0 = 9'd0; cmd_y0 = 8'd0; cmd_w = 9'd4; cmd_h = 8'd4; cmd_color = 4'h3;
    cmd_valid = 1'b1;
    @(negedge Clk);
    @(posedge Clk); #1;
    cmd_valid = 1'b0;
    nw = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clk);
      if (write_en) nw++;
      if (c == 4) Reset = 1'b0;
      else begin
        @(posedge Clk); #1;
      end
    end
    check("midrst writes_before", nw, 4);
    @(posedge Clk); #1;
    @(negedge Clk);
    check("midrst write_en", int'(write_en), 0);
    check("midrst cmd_ready", int'(cmd_ready), 1);
    check("midrst busy", int'(busy), 0);
    check("midrst done", int'(done), 0);
    check("midrst addr", int'(write_address), 0);
    check("midrst data", int'(write_data), 0);
    Reset = 1'b1;
    @(posedge Clk); #1;
    @(negedge Clk);
    check("midrst no_done", int'(done), 0);
    check("midrst idle", int'(cmd_ready), 1);
    @(posedge Clk); #1;
    run_cmd(10, vecs[0]);

    run_cmd(9, vecs[9]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
